// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encodings, opcode/funct constants, ALU codes and ID decode for mc_ctrl_unit.
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3, S_WB_LW = 4'd4,
    S_MEM_WR = 4'd5, S_EX_R = 4'd6, S_WB_R = 4'd7, S_BR = 4'd8, S_JMP = 4'd9,
    S_EX_I = 4'd10, S_WB_I = 4'd11, S_INT_ENTRY = 4'd12, S_ERR = 4'd13
  } state_t;
  typedef enum logic [1:0] {AC_ADD, AC_SUB, AC_FUNCT, AC_IMM} alu_cls_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ORI = 6'b001101, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ERET = 6'b010000;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_NOR = 6'b100111;
  localparam logic [5:0] FN_ERET = 6'b011000;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100, ALU_SUB = 3'b110, ALU_SLT = 3'b111;
  // S_IF as a result means the opcode is illegal
  function automatic state_t decode(input logic [5:0] op, input logic [5:0] fn, input bit int_en);
    return op == OP_R ? S_EX_R :
           (op == OP_LW || op == OP_SW) ? S_MEM_ADDR :
           (op == OP_BEQ || op == OP_BNE) ? S_BR :
           (op == OP_J || (int_en && op == OP_ERET && fn == FN_ERET)) ? S_JMP :
           (op == OP_ADDI || op == OP_ORI || op == OP_SLTI) ? S_EX_I : S_IF;
  endfunction
endpackage

// File: rtl/mc_ctrl_unit_if.sv
// mc_ctrl_unit_if: instruction/status inputs and control outputs between controller and datapath.
interface mc_ctrl_unit_if #(parameter int STATE_W = 5);
  logic [5:0] opcode, funct;
  logic zero, MIO_ready, INT;
  logic PCWrite, PCWriteCond, IorD, MemRead, mem_w, IRWrite, RegDst, MemtoReg, RegWrite;
  logic ALUSrcA, CPU_MIO, EPCWrite, illegal_op, mem_timeout;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALU_Control;
  logic [STATE_W-1:0] state;
  modport master(
    input opcode, funct, zero, MIO_ready, INT,
    output PCWrite, PCWriteCond, IorD, MemRead, mem_w, IRWrite, RegDst, MemtoReg, RegWrite,
    output ALUSrcA, CPU_MIO, EPCWrite, illegal_op, mem_timeout, ALUSrcB, PCSource, ALU_Control, state
  );
  modport slave(
    output opcode, funct, zero, MIO_ready, INT,
    input PCWrite, PCWriteCond, IorD, MemRead, mem_w, IRWrite, RegDst, MemtoReg, RegWrite,
    input ALUSrcA, CPU_MIO, EPCWrite, illegal_op, mem_timeout, ALUSrcB, PCSource, ALU_Control, state
  );
endinterface

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational ALU_Control from state class, opcode and funct.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);
  logic [2:0] fn_alu, imm_alu;
  always_comb begin
    fn_alu = funct == FN_SUB ? ALU_SUB : funct == FN_AND ? ALU_AND : funct == FN_OR ? ALU_OR :
             funct == FN_SLT ? ALU_SLT : funct == FN_NOR ? ALU_NOR : ALU_ADD;
    imm_alu = opcode == OP_ORI ? ALU_OR : opcode == OP_SLTI ? ALU_SLT : ALU_ADD;
    alu_ctrl = cls == AC_SUB ? ALU_SUB : cls == AC_FUNCT ? fn_alu : cls == AC_IMM ? imm_alu : ALU_ADD;
  end
endmodule

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multicycle MIPS control FSM with memory-wait timeout.
// Define MCTRL_INT_EN to enable interrupt entry and eret.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int         STATE_W     = 5,
  parameter int         TIMEOUT_W   = 8,
  parameter logic [1:0] INT_VEC_SEL = 2'b11
) (
  input logic clk,
  input logic reset,
  mc_ctrl_unit_if.master bus
);
`ifdef MCTRL_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif
  state_t cur, nxt, id_nxt, fin;
  alu_cls_t cls;
  logic [TIMEOUT_W-1:0] cnt;
  logic mask, wait_st, tmo, eret, taken;
  assign id_nxt  = decode(bus.opcode, bus.funct, INT_EN);
  assign eret    = INT_EN && bus.opcode == OP_ERET && bus.funct == FN_ERET;
  assign wait_st = cur == S_IF || cur == S_MEM_RD || cur == S_MEM_WR;
  // this wait cycle is the one that brings the count to 2^TIMEOUT_W-1
  assign tmo     = wait_st && !bus.MIO_ready && cnt == ~TIMEOUT_W'(1);
  assign fin     = INT_EN && bus.INT && !mask ? S_INT_ENTRY : S_IF;
  assign taken   = bus.opcode == OP_BNE ? !bus.zero : bus.zero;
  always_ff @(posedge clk)
    if (!reset) cur <= S_IF;
    else cur <= nxt;
  always_ff @(posedge clk)
    if (!reset) begin
      cnt  <= '0;
      mask <= 1'b0;
    end else begin
      cnt  <= nxt != cur ? '0 : wait_st && !bus.MIO_ready ? cnt + TIMEOUT_W'(1) : cnt;
      mask <= cur == S_INT_ENTRY ? 1'b1 : cur == S_JMP && eret ? 1'b0 : mask;
    end
  always_comb begin
    nxt = cur;
    case (cur)
      S_IF:        nxt = tmo ? S_ERR : bus.MIO_ready ? S_ID : S_IF;
      S_ID:        nxt = id_nxt;
      S_MEM_ADDR:  nxt = bus.opcode == OP_SW ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    nxt = tmo ? S_ERR : bus.MIO_ready ? S_WB_LW : S_MEM_RD;
      S_MEM_WR:    nxt = tmo ? S_ERR : bus.MIO_ready ? fin : S_MEM_WR;
      S_EX_R:      nxt = S_WB_R;
      S_EX_I:      nxt = S_WB_I;
      S_WB_LW, S_WB_R, S_WB_I, S_BR, S_JMP: nxt = fin;
      S_ERR:       nxt = S_ERR;
      default:     nxt = S_IF;
    endcase
  end
  always_comb begin
    {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.mem_w, bus.IRWrite, bus.RegDst,
     bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.CPU_MIO, bus.EPCWrite, bus.mem_timeout} = '0;
    bus.ALUSrcB  = 2'b00;
    bus.PCSource = 2'b00;
    cls          = AC_ADD;
    case (cur)
      S_IF:        begin bus.CPU_MIO = 1'b1; bus.MemRead = 1'b1; bus.ALUSrcB = 2'b01; bus.IRWrite = bus.MIO_ready; bus.PCWrite = bus.MIO_ready; end
      S_ID:        bus.ALUSrcB = 2'b11;
      S_MEM_ADDR:  begin bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; end
      S_MEM_RD:    begin bus.CPU_MIO = 1'b1; bus.MemRead = 1'b1; bus.IorD = 1'b1; end
      S_WB_LW:     begin bus.RegWrite = 1'b1; bus.MemtoReg = 1'b1; end
      S_MEM_WR:    begin bus.CPU_MIO = 1'b1; bus.IorD = 1'b1; bus.mem_w = bus.MIO_ready && reset; end
      S_EX_R:      begin bus.ALUSrcA = 1'b1; cls = AC_FUNCT; end
      S_WB_R:      begin bus.RegWrite = 1'b1; bus.RegDst = 1'b1; end
      S_BR:        begin bus.ALUSrcA = 1'b1; bus.PCWriteCond = taken; bus.PCSource = 2'b01; cls = AC_SUB; end
      S_JMP:       begin bus.PCWrite = 1'b1; bus.PCSource = eret ? INT_VEC_SEL ^ 2'b01 : 2'b10; end
      S_EX_I:      begin bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; cls = AC_IMM; end
      S_WB_I:      bus.RegWrite = 1'b1;
      S_INT_ENTRY: begin bus.EPCWrite = INT_EN; bus.PCWrite = 1'b1; bus.PCSource = INT_VEC_SEL; end
      S_ERR:       bus.mem_timeout = 1'b1;
      default:     ;
    endcase
    bus.illegal_op = cur == S_ID && id_nxt == S_IF;
  end
  assign bus.state = STATE_W'(cur);
  mc_alu_dec u_alu_dec (.cls(cls), .opcode(bus.opcode), .funct(bus.funct), .alu_ctrl(bus.ALU_Control));
endmodule
